// File: rtl/vdp99_bus_master.sv
// vdp99_bus_master: bus initiator for the vdp99 CPU port.
// Turns accepted commands into timed mode/data/wr/rd strobe cycles of one
// or two bytes each. All logic runs on phi.
module vdp99_bus_master #(
  parameter int SETUP_CYC   = 1,  // cycles mode/data lead the strobe (1..15)
  parameter int STROBE_CYC  = 4,  // strobe high time (1..15)
  parameter int RECOVER_CYC = 8   // idle time after each byte (0..15)
) (
  input  logic        phi,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [13:0] cmd_arg,
  input  logic [7:0]  cmd_data,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        bus_mode,
  output logic [7:0]  bus_dout,
  input  logic [7:0]  bus_din,
  output logic        bus_wr,
  output logic        bus_rd,
  output logic        busy
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD, ST_RECOVER
  } state_t;

  localparam logic [2:0] OP_WRDATA   = 3'd0;
  localparam logic [2:0] OP_RDDATA   = 3'd1;
  localparam logic [2:0] OP_WRREG    = 3'd2;
  localparam logic [2:0] OP_SETWADDR = 3'd3;
  localparam logic [2:0] OP_SETRADDR = 3'd4;
  localparam logic [2:0] OP_RDSTAT   = 3'd5;

  // Counters are loaded with N-1 and exit a state when they reach zero.
  localparam logic [3:0] SETUP_LOAD   = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LOAD  = 4'(STROBE_CYC - 1);
  localparam logic [3:0] RECOVER_LOAD = 4'(RECOVER_CYC - 1);

  state_t      state_q, state_n;
  logic [3:0]  cnt_q, cnt_n;
  logic        idx_q, idx_n;      // 0 = first byte, 1 = second byte
  logic [2:0]  op_q;
  logic [13:0] arg_q;
  logic [7:0]  data_q;

  logic        accept;
  logic        byte_done;
  logic [2:0]  nxt_op;
  logic [8:0]  nxt_byte;          // {mode, byte} for the byte about to be set up

  function automatic logic is_read(input logic [2:0] op);
    return (op == OP_RDDATA) || (op == OP_RDSTAT);
  endfunction

  function automatic logic is_two_byte(input logic [2:0] op);
    return (op == OP_WRREG) || (op == OP_SETWADDR) || (op == OP_SETRADDR);
  endfunction

  // {mode, byte} for each byte of each command; read bytes only carry the mode.
  function automatic logic [8:0] byte_of(input logic [2:0] op, input logic [13:0] arg,
                                         input logic [7:0] data, input logic idx);
    case (op)
      OP_WRDATA:   return {1'b0, data};
      OP_RDDATA:   return {1'b0, 8'h00};
      OP_RDSTAT:   return {1'b1, 8'h00};
      OP_WRREG:    return idx ? {1'b1, 8'h80 | {5'b0, arg[2:0]}} : {1'b1, data};
      OP_SETWADDR: return idx ? {1'b1, 8'h40 | {2'b0, arg[13:8]}} : {1'b1, arg[7:0]};
      OP_SETRADDR: return idx ? {1'b1, {2'b0, arg[13:8]}} : {1'b1, arg[7:0]};
      default:     return 9'h000;
    endcase
  endfunction

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = ~cmd_ready;
  assign accept    = cmd_valid & cmd_ready;
  assign rsp_valid = (state_q == ST_HOLD) && is_read(op_q);

  // Next-state and counter logic for the byte-cycle sequencer.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_n   = state_q;
    cnt_n     = cnt_q;
    idx_n     = idx_q;
    byte_done = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Reserved ops are accepted but never leave IDLE.
        if (accept && (cmd_op <= OP_RDSTAT)) begin
          state_n = ST_SETUP;
          cnt_n   = SETUP_LOAD;
          idx_n   = 1'b0;
        end
      end
      ST_SETUP: begin
        if (cnt_q == 4'd0) begin
          state_n = ST_STROBE;
          cnt_n   = STROBE_LOAD;
        end else begin
          cnt_n = cnt_q - 4'd1;
        end
      end
      ST_STROBE: begin
        if (cnt_q == 4'd0) begin
          state_n = ST_HOLD;
          cnt_n   = 4'd0;
        end else begin
          cnt_n = cnt_q - 4'd1;
        end
      end
      ST_HOLD: begin
        if (RECOVER_CYC == 0) begin
          byte_done = 1'b1;
        end else begin
          state_n = ST_RECOVER;
          cnt_n   = RECOVER_LOAD;
        end
      end
      ST_RECOVER: begin
        if (cnt_q == 4'd0) byte_done = 1'b1;
        else               cnt_n = cnt_q - 4'd1;
      end
      default: state_n = ST_IDLE;
    endcase

    if (byte_done) begin
      if (is_two_byte(op_q) && !idx_q) begin
        state_n = ST_SETUP;
        cnt_n   = SETUP_LOAD;
        idx_n   = 1'b1;
      end else begin
        state_n = ST_IDLE;
        cnt_n   = 4'd0;
      end
    end

    // On the accept edge the latched command is not yet valid, so look through.
    nxt_op   = accept ? cmd_op : op_q;
    nxt_byte = accept ? byte_of(cmd_op, cmd_arg, cmd_data, idx_n)
                      : byte_of(op_q, arg_q, data_q, idx_n);
  end

  // State, command latch and registered (glitch-free) bus outputs.
  always_ff @(posedge phi or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      idx_q    <= 1'b0;
      op_q     <= 3'd0;
      arg_q    <= 14'd0;
      data_q   <= 8'd0;
      bus_mode <= 1'b0;
      bus_dout <= 8'd0;
      bus_wr   <= 1'b0;
      bus_rd   <= 1'b0;
      rsp_data <= 8'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q <= state_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
      if (accept) begin
        op_q   <= cmd_op;
        arg_q  <= cmd_arg;
        data_q <= cmd_data;
      end
      bus_wr <= (state_n == ST_STROBE) && !is_read(nxt_op);
      bus_rd <= (state_n == ST_STROBE) && is_read(nxt_op);
      if (state_n == ST_SETUP) begin
        bus_mode <= nxt_byte[8];
        if (!is_read(nxt_op)) bus_dout <= nxt_byte[7:0];
      end
      if ((state_q == ST_STROBE) && (cnt_q == 4'd0) && is_read(op_q))
        rsp_data <= bus_din;
    end
  end

endmodule

// File: tb/tb_vdp99_bus_master.sv
// tb_vdp99_bus_master: directed self-checking bench for vdp99_bus_master
// with default timing (SETUP 1, STROBE 4, RECOVER 8).
module tb_vdp99_bus_master;

  logic        phi = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [13:0] cmd_arg = 14'd0;
  logic [7:0]  cmd_data = 8'd0;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        bus_mode;
  logic [7:0]  bus_dout;
  logic [7:0]  bus_din = 8'd0;
  logic        bus_wr;
  logic        bus_rd;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Per-transaction observation masks, bit k = cycle k after the accept edge.
  logic [63:0] wr_m, rd_m, rdy_m, rv_m;
  logic        mode3;
  logic [7:0]  dout3;

  // Write-strobe monitor: logs {mode, byte} at each rising bus_wr.
  logic [8:0]  wr_log[$];
  int          wr_edges = 0;
  logic        wr_prev = 1'b0;
  logic        overlap = 1'b0;

  vdp99_bus_master dut (
    .phi       (phi),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .bus_mode  (bus_mode),
    .bus_dout  (bus_dout),
    .bus_din   (bus_din),
    .bus_wr    (bus_wr),
    .bus_rd    (bus_rd),
    .busy      (busy)
  );

  always #5 phi = ~phi;

  // Observe strobes away from the active edge.
  always @(negedge phi) begin
    if (bus_wr && !wr_prev) begin
      wr_log.push_back({bus_mode, bus_dout});
      wr_edges++;
    end
    if (bus_wr && bus_rd) overlap = 1'b1;
    wr_prev = bus_wr;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command, then sample cycles 1..n after the accept edge.
  task automatic txn(input logic [2:0] op, input logic [13:0] arg,
                     input logic [7:0] data, input int n);
    @(negedge phi);
    check("ready_at_issue", 64'(cmd_ready), 64'h1);
    cmd_op    = op;
    cmd_arg   = arg;
    cmd_data  = data;
    cmd_valid = 1'b1;
    @(posedge phi);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;          // scrambled: must not affect the running command
    cmd_arg   = 14'h2AAA;
    cmd_data  = 8'h00;
    wr_m  = '0;
    rd_m  = '0;
    rdy_m = '0;
    rv_m  = '0;
    mode3 = 1'b0;
    dout3 = 8'h00;
    for (int k = 1; k <= n; k++) begin
      @(negedge phi);
      wr_m[k]  = bus_wr;
      rd_m[k]  = bus_rd;
      rdy_m[k] = cmd_ready;
      rv_m[k]  = rsp_valid;
      if (k == 3) begin
        mode3 = bus_mode;
        dout3 = bus_dout;
      end
    end
  endtask

  initial begin
    int guard;

    // Reset state.
    repeat (2) @(negedge phi);
    check("reset_ready", 64'(cmd_ready), 64'h1);
    check("reset_ctrl", 64'({busy, bus_wr, bus_rd, bus_mode, rsp_valid}), 64'h0);
    check("reset_dout", 64'(bus_dout), 64'h0);
    check("reset_rsp", 64'(rsp_data), 64'h0);
    reset_n = 1'b1;
    @(negedge phi);
    check("post_reset_strobes", 64'({bus_wr, bus_rd}), 64'h0);

    // WRDATA AA: strobe cycles 2..5, ready again at 15.
    wr_log.delete();
    txn(3'd0, 14'd0, 8'hAA, 15);
    check("wrdata_wr_mask", wr_m, 64'h0000_0000_0000_003C);
    check("wrdata_rd_mask", rd_m, 64'h0);
    check("wrdata_ready_mask", rdy_m, 64'h0000_0000_0000_8000);
    check("wrdata_mode", 64'(mode3), 64'h0);
    check("wrdata_dout", 64'(dout3), 64'hAA);
    check("wrdata_log_size", 64'(wr_log.size()), 64'd1);
    check("wrdata_log0", 64'(wr_log[0]), 64'h0AA);

    // WRREG 7, F5: bytes F5 then 87, strobes 2..5 and 16..19, ready at 29.
    wr_log.delete();
    txn(3'd2, 14'd7, 8'hF5, 29);
    check("wrreg_wr_mask", wr_m, 64'h0000_0000_000F_003C);
    check("wrreg_ready_mask", rdy_m, 64'h0000_0000_2000_0000);
    check("wrreg_log_size", 64'(wr_log.size()), 64'd2);
    check("wrreg_log0", 64'(wr_log[0]), 64'h1F5);
    check("wrreg_log1", 64'(wr_log[1]), 64'h187);

    // SETWADDR 3FFF then SETRADDR 0123.
    wr_log.delete();
    txn(3'd3, 14'h3FFF, 8'h00, 29);
    check("setw_ready_mask", rdy_m, 64'h0000_0000_2000_0000);
    txn(3'd4, 14'h0123, 8'h00, 29);
    check("addr_log_size", 64'(wr_log.size()), 64'd4);
    check("setw_lo", 64'(wr_log[0]), 64'h1FF);
    check("setw_hi", 64'(wr_log[1]), 64'h17F);
    check("setr_lo", 64'(wr_log[2]), 64'h123);
    check("setr_hi", 64'(wr_log[3]), 64'h101);

    // RDSTAT with bus_din 9F.
    bus_din = 8'h9F;
    txn(3'd5, 14'd0, 8'h00, 15);
    check("rdstat_rd_mask", rd_m, 64'h0000_0000_0000_003C);
    check("rdstat_wr_mask", wr_m, 64'h0);
    check("rdstat_rv_mask", rv_m, 64'h0000_0000_0000_0040);
    check("rdstat_ready_mask", rdy_m, 64'h0000_0000_0000_8000);
    check("rdstat_mode", 64'(mode3), 64'h1);
    check("rdstat_data", 64'(rsp_data), 64'h9F);
    bus_din = 8'h00;
    repeat (5) @(negedge phi);
    check("rdstat_data_held", 64'(rsp_data), 64'h9F);

    // RDDATA with bus_din 5A: data port.
    bus_din = 8'h5A;
    txn(3'd1, 14'd0, 8'h00, 15);
    check("rddata_mode", 64'(mode3), 64'h0);
    check("rddata_rv_mask", rv_m, 64'h0000_0000_0000_0040);
    check("rddata_data", 64'(rsp_data), 64'h5A);

    // Reserved op: no bus activity, ready from cycle 1.
    txn(3'd6, 14'd0, 8'h00, 3);
    check("reserved_strobes", wr_m | rd_m, 64'h0);
    check("reserved_ready_mask", rdy_m, 64'h0000_0000_0000_000E);

    // cmd_valid held for 40 edges: accepts at edges 1, 16, 31 only.
    @(negedge phi);
    wr_edges  = 0;
    cmd_op    = 3'd0;
    cmd_data  = 8'h3C;
    cmd_valid = 1'b1;
    repeat (40) @(posedge phi);
    #1;
    cmd_valid = 1'b0;
    repeat (20) @(negedge phi);
    check("held_valid_txns", 64'(wr_edges), 64'd3);
    check("held_valid_idle", 64'(cmd_ready), 64'h1);

    // Reset during STROBE drops bus_wr without waiting for phi.
    cmd_op    = 3'd0;
    cmd_data  = 8'h11;
    cmd_valid = 1'b1;
    @(posedge phi);
    #1;
    cmd_valid = 1'b0;
    guard = 0;
    while (!bus_wr && guard < 10) begin
      @(negedge phi);
      guard++;
    end
    check("strobe_seen_before_reset", 64'(bus_wr), 64'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_wr", 64'(bus_wr), 64'h0);
    check("async_reset_ready", 64'(cmd_ready), 64'h1);
    check("async_reset_outs", 64'({busy, bus_rd, bus_mode, rsp_valid}), 64'h0);
    check("async_reset_data", 64'({bus_dout, rsp_data}), 64'h0);
    @(negedge phi);
    reset_n = 1'b1;
    @(posedge phi);
    #1;
    check("release_no_strobe", 64'({bus_wr, bus_rd}), 64'h0);
    check("release_ready", 64'(cmd_ready), 64'h1);

    check("no_wr_rd_overlap", 64'(overlap), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
